// File: rtl/tape_punch.sv
// Paper tape punch model: 5-hole PL6 punch with motor spin-up, solenoid and
// advance timing from the 1 ms tick, plus a tape image FIFO for the host.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   tick_ms           1 ms strobe from timer
//   PUNCH_CODE/REQ    code and level request from the computer
//   SW_TAPE_FEED      manual feed switch, punches blank frames
//   PUNCH_READY       a code can be accepted this clk
//   PUNCH_MOTOR       motor drive
//   PUNCH_SOL         solenoid drive, bit0 = hole 1
//   PL6_TAPE_RUN_SW   frame in progress (punch through advance)
//   tape_data/valid   oldest buffered frame, FIFO not empty
//   tape_pop          consume tape_data
//   tape_overflow     sticky frame-lost flag
//   tape_count        frames currently buffered
module tape_punch #(
    parameter int SPINUP_MS     = 50,
    parameter int SOLENOID_MS   = 10,
    parameter int CYCLE_MS      = 60,
    parameter int MOTOR_IDLE_MS = 1000,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tick_ms,
    input  logic [4:0]                  PUNCH_CODE,
    input  logic                        PUNCH_REQ,
    input  logic                        SW_TAPE_FEED,
    output logic                        PUNCH_READY,
    output logic                        PUNCH_MOTOR,
    output logic [4:0]                  PUNCH_SOL,
    output logic                        PL6_TAPE_RUN_SW,
    output logic [4:0]                  tape_data,
    output logic                        tape_valid,
    input  logic                        tape_pop,
    output logic                        tape_overflow,
    output logic [$clog2(FIFO_DEPTH):0] tape_count
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int MAX_A  = (SPINUP_MS > CYCLE_MS) ? SPINUP_MS : CYCLE_MS;
    localparam int MAX_MS = (MAX_A > MOTOR_IDLE_MS) ? MAX_A : MOTOR_IDLE_MS;
    localparam int CW     = $clog2(MAX_MS + 1);

    typedef enum logic [2:0] {
        OFF,
        SPINUP,
        PUNCH,
        ADVANCE,
        RUN_IDLE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_ms;
    logic [4:0]      r_code;
    logic            w_accept;
    logic            w_push;

    logic [4:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wp;
    logic [AW-1:0]   r_rp;
    logic [AW:0]     r_cnt;
    logic            w_full;
    logic            w_pop;
    logic            w_push_ok;

    function automatic logic expires(input logic [CW-1:0] ms, input int n);
        return tick_ms && (ms == CW'(n - 1));
    endfunction

    always_comb begin
        w_state_nxt     = r_state;
        w_accept        = 1'b0;
        w_push          = 1'b0;
        PUNCH_READY     = 1'b0;
        PUNCH_MOTOR     = 1'b1;
        PUNCH_SOL       = 5'd0;
        PL6_TAPE_RUN_SW = 1'b0;
        unique case (r_state)
            OFF: begin
                PUNCH_READY = 1'b1;
                PUNCH_MOTOR = 1'b0;
                w_accept    = PUNCH_REQ | SW_TAPE_FEED;
                if (w_accept)
                    w_state_nxt = SPINUP;
            end
            SPINUP: begin
                if (expires(r_ms, SPINUP_MS))
                    w_state_nxt = PUNCH;
            end
            PUNCH: begin
                PUNCH_SOL       = r_code;
                PL6_TAPE_RUN_SW = 1'b1;
                if (expires(r_ms, SOLENOID_MS)) begin
                    w_state_nxt = ADVANCE;
                    w_push      = 1'b1;
                end
            end
            ADVANCE: begin
                PL6_TAPE_RUN_SW = 1'b1;
                if (expires(r_ms, CYCLE_MS - SOLENOID_MS))
                    w_state_nxt = RUN_IDLE;
            end
            RUN_IDLE: begin
                PUNCH_READY = 1'b1;
                w_accept    = PUNCH_REQ | SW_TAPE_FEED;
                // a new request wins over motor run-on expiry
                if (w_accept)
                    w_state_nxt = PUNCH;
                else if (expires(r_ms, MOTOR_IDLE_MS))
                    w_state_nxt = OFF;
            end
            default: w_state_nxt = OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= OFF;
            r_ms    <= '0;
            r_code  <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            // the counter restarts on every state entry, so a tick on the
            // transition clk never counts toward the new state
            if (w_state_nxt != r_state)
                r_ms <= '0;
            else if (tick_ms && r_state != OFF)
                r_ms <= r_ms + 1'b1;
            if (w_accept)
                r_code <= PUNCH_REQ ? PUNCH_CODE : 5'd0;
        end
    end

    assign w_full    = (r_cnt == (AW+1)'(FIFO_DEPTH));
    assign w_pop     = tape_pop && (r_cnt != '0);
    // a pop on the same clk frees the slot a full FIFO needs
    assign w_push_ok = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp          <= '0;
            r_rp          <= '0;
            r_cnt         <= '0;
            tape_overflow <= 1'b0;
        end else begin
            if (w_push_ok)
                r_wp <= r_wp + 1'b1;
            if (w_pop)
                r_rp <= r_rp + 1'b1;
            if (w_push_ok && !w_pop)
                r_cnt <= r_cnt + 1'b1;
            else if (!w_push_ok && w_pop)
                r_cnt <= r_cnt - 1'b1;
            if (w_push && !w_push_ok)
                tape_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wp] <= r_code;
    end

    assign tape_valid = (r_cnt != '0);
    assign tape_data  = tape_valid ? r_mem[r_rp] : 5'd0;
    assign tape_count = r_cnt;

endmodule
